// File: rtl/game_txt_overlay.sv
// Text-overlay stage: turns the beam position into text/font ROM addresses and
// paints glyph pixels over the background, keeping all VGA timing 4 clk aligned.
module game_txt_overlay #(
    parameter int          XPOS         = 64,
    parameter int          YPOS         = 64,
    parameter logic [11:0] FG_COLOR     = 12'hFFF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        txt_en,
    input  logic        blink_en,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    input  logic [7:0]  char_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_box;
        logic [2:0]  dx_lo;
    } stage_t;

    // Only the low bits of the box-relative offsets are ever used, so the
    // subtraction is done at that width; wrap-around is harmless inside the box.
    logic [6:0] dx;
    logic [5:0] dy;
    logic       in_box;
    stage_t     cur;
    stage_t     pipe [3];
    logic [3:0] line_d1;
    logic       vsync_prev;
    logic [CW-1:0] frame_cnt;
    logic       vis;
    logic       pixel_on;
    logic       draw;

    assign dx = hcount_in[6:0] - 7'(XPOS);
    assign dy = vcount_in[5:0] - 6'(YPOS);

    always_comb begin
        in_box = (int'(hcount_in) >= XPOS) && (int'(hcount_in) < XPOS + 128) &&
                 (int'(vcount_in) >= YPOS) && (int'(vcount_in) < YPOS + 64);
        cur = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
               rgb_in, in_box, dx[2:0]};
    end

    // By stage 3 the font ROM row for this pixel sits on char_pixels.
    always_comb begin
        pixel_on = char_pixels[3'd7 - pipe[2].dx_lo];
        draw     = pixel_on & pipe[2].in_box & txt_en & (vis | ~blink_en) &
                   ~pipe[2].hblnk & ~pipe[2].vblnk;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; the pipeline registers are
    // reset too, because the outputs must read zero right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) pipe[i] <= '0;
            char_xy    <= '0;
            line_d1    <= '0;
            char_line  <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            pipe[0]    <= cur;
            pipe[1]    <= pipe[0];
            pipe[2]    <= pipe[1];
            char_xy    <= in_box ? {2'b00, dy[5:4], dx[6:3]} : 8'h00;
            line_d1    <= dy[3:0];
            char_line  <= line_d1;
            hcount_out <= pipe[2].hcount;
            vcount_out <= pipe[2].vcount;
            hsync_out  <= pipe[2].hsync;
            vsync_out  <= pipe[2].vsync;
            hblnk_out  <= pipe[2].hblnk;
            vblnk_out  <= pipe[2].vblnk;
            rgb_out    <= draw ? FG_COLOR : pipe[2].rgb;
        end
    end

    // Blink counter advances once per frame on the vsync rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev <= 1'b0;
            frame_cnt  <= '0;
            vis        <= 1'b1;
        end else begin
            vsync_prev <= vsync_in;
            if (!blink_en) begin
                frame_cnt <= '0;
                vis       <= 1'b1;
            end else if (vsync_in && !vsync_prev) begin
                if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    vis       <= ~vis;
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end

endmodule
